keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - ROWS x COLS keypad scanner with debounce and event FIFO; optional KEYPAD_RELEASE_EVENTS_EN adds release events
module keypad_scanner #(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int SETTLE_CYCLES  = 1000,
    parameter  int DEBOUNCE_SCANS = 8,
    parameter  int FIFO_DEPTH     = 8,
    localparam int CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [COLS-1:0]   cols,
    input  logic [ROWS-1:0]   rows,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_down,
    output logic [CODE_W-1:0] key_down_code,
    output logic              overflow
);

    localparam int NKEYS = ROWS * COLS;
    localparam int COL_W = $clog2(COLS);
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVENTS_EN
    localparam int ENTRY_W = CODE_W + 1;
`else
    localparam int ENTRY_W = CODE_W;
`endif
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W + 1)'(FIFO_DEPTH);

    logic [COL_W-1:0]   col_q, col_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [NKEYS-1:0]   snap_q, snap_d;
    logic               scan_done_q, scan_done_d;
    logic               cand_key_q, cand_key_d;
    logic [CODE_W-1:0]  cand_code_q, cand_code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stab_key_q, stab_key_d;
    logic [CODE_W-1:0]  stab_code_q, stab_code_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

    logic               hit_any, hit_multi, same_as_cand, differs_stable;
    logic [CODE_W-1:0]  hit_code;
    logic               push_req, do_push, do_pop, full;
    logic [CODE_W-1:0]  push_code;
    logic [ENTRY_W-1:0] push_entry, head;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    logic               push_rel;
`endif

    assign cols = COLS'(1) << col_q;

    // Column strobe and settle timing; capture the driven column's rows on its last settle cycle
    always_comb begin
        col_d       = col_q;
        settle_d    = settle_q + 1'b1;
        snap_d      = snap_q;
        scan_done_d = 1'b0;
        if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            snap_d[int'(col_q) * ROWS +: ROWS] = rows;
            if (col_q == COL_LAST) begin
                col_d       = '0;
                scan_done_d = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Classify the completed snapshot as none / single key / multiple keys
    always_comb begin
        hit_any   = 1'b0;
        hit_multi = 1'b0;
        hit_code  = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (snap_q[i]) begin
                if (hit_any) hit_multi = 1'b1;
                hit_any  = 1'b1;
                hit_code = CODE_W'(i);
            end
        end
    end

    // Debounce the classified scan and decide stable-state changes and FIFO pushes
    always_comb begin
        cand_key_d  = cand_key_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        stab_key_d  = stab_key_q;
        stab_code_d = stab_code_q;
        push_req    = 1'b0;
        push_code   = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
        push_rel    = 1'b0;
`endif
        same_as_cand = (hit_any == cand_key_q) && (!hit_any || hit_code == cand_code_q);
        if (scan_done_q && !hit_multi) begin
            if (same_as_cand) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_key_d  = hit_any;
                cand_code_d = hit_any ? hit_code : '0;
                cnt_d       = CNT_W'(1);
            end
        end
        differs_stable = (cand_key_d != stab_key_q) ||
                         (cand_key_d && cand_code_d != stab_code_q);
        if (scan_done_q && cnt_d == CNT_MAX && differs_stable) begin
            if (!stab_key_q) begin
                stab_key_d  = 1'b1;
                stab_code_d = cand_code_d;
                push_req    = 1'b1;
                push_code   = cand_code_d;
            end else begin
                // Key-to-key swaps pass through NONE so the new key debounces from scratch
                stab_key_d  = 1'b0;
                stab_code_d = '0;
                if (cand_key_d) cnt_d = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
                push_req  = 1'b1;
                push_rel  = 1'b1;
                push_code = stab_code_q;
`endif
            end
        end
    end

`ifdef KEYPAD_RELEASE_EVENTS_EN
    assign push_entry  = {push_rel, push_code};
    assign key_code    = key_valid ? head[CODE_W-1:0] : '0;
    assign key_release = key_valid & head[CODE_W];
`else
    assign push_entry  = push_code;
    assign key_code    = key_valid ? head : '0;
    assign key_release = 1'b0;
`endif

    assign head          = mem_q[rd_ptr_q];
    assign key_valid     = (count_q != '0);
    assign key_down      = stab_key_q;
    assign key_down_code = stab_code_q;
    assign overflow      = ovf_q;
    assign full          = (count_q == FULL_CNT);
    assign do_pop        = key_valid && key_ready;
    assign do_push       = push_req && (!full || do_pop);

    // FIFO pointer/occupancy bookkeeping; a pop frees room for a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_req && full && !do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // State registers; reset discards queued events and restarts scanning at column 0
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            settle_q    <= '0;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
            cand_key_q  <= 1'b0;
            cand_code_q <= '0;
            cnt_q       <= '0;
            stab_key_q  <= 1'b0;
            stab_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            settle_q    <= settle_d;
            snap_q      <= snap_d;
            scan_done_q <= scan_done_d;
            cand_key_q  <= cand_key_d;
            cand_code_q <= cand_code_d;
            cnt_q       <= cnt_d;
            stab_key_q  <= stab_key_d;
            stab_code_q <= stab_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Event storage; contents are only visible through the valid-gated head
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule
